// File: rtl/nikon_emu_pkg.sv
// nikon_emu_pkg: shared constants and FSM state type for the Nikon encoder emulator.
package nikon_emu_pkg;

  localparam logic [4:0] CMD_READ_ALL  = 5'd0;
  localparam logic [4:0] CMD_ALARM_CLR = 5'd1;
  localparam logic [2:0] SYNC_WORD     = 3'b010;
  localparam logic [2:0] CRC3_POLY     = 3'b011;  // x^3 + x + 1
  localparam logic [7:0] CRC8_POLY     = 8'h07;
  localparam int         REQ_BITS      = 16;      // start + 14 field bits + stop
  localparam int         FRAME_BITS    = 18;      // start + 16 data + stop

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RX,
    ST_CHECK,
    ST_TURN,
    ST_TX
  } state_t;

endpackage

// File: rtl/nikon_encoder_emu_if.sv
// nikon_encoder_emu_if: half-duplex RS-485 line between encoder-read initiator
// (master) and the encoder emulator (slave).
interface nikon_encoder_emu_if;
  logic iRx;   // request data toward the emulator, idle high
  logic oTx;   // response data from the emulator, idle high
  logic oDir;  // emulator driver enable, 1 = transmitting

  modport master (output iRx, input oTx, input oDir);
  modport slave  (input iRx, output oTx, output oDir);
endinterface

// File: rtl/nikon_emu_crc.sv
// nikon_emu_crc: serial MSB-first CRC register, one data bit per enabled cycle.
module nikon_emu_crc #(
  parameter int           W    = 3,
  parameter logic [W-1:0] POLY = 3'b011
) (
  input  logic         iClk,
  input  logic         iRst,
  input  logic         iClr,
  input  logic         iEn,
  input  logic         iDin,
  output logic [W-1:0] oCrc
);
  logic [W-1:0] crc_q, crc_d;
  logic         fb;

  // Next CRC value: clear wins over shift.
  always_comb begin
    fb    = crc_q[W-1] ^ iDin;
    crc_d = crc_q;
    if (iClr)     crc_d = '0;
    else if (iEn) crc_d = {crc_q[W-2:0], 1'b0} ^ (fb ? POLY : '0);
  end

  // CRC register.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) crc_q <= '0;
    else      crc_q <= crc_d;
  end

  assign oCrc = crc_q;
endmodule

// File: rtl/nikon_encoder_emu.sv
// nikon_encoder_emu: responder end of the Nikon absolute-encoder serial link.
// Decodes request frames, snapshots position/alarm and answers on the line.
// Build macro NIKON_EMU_CRC_EN: when defined, request CRC3 is checked and the
// response CRC8 is generated; otherwise the crc3 field is ignored and crc8 is 0.
module nikon_encoder_emu
  import nikon_emu_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 20,
  parameter logic [2:0] ENC_ADDR     = 3'd0,
  parameter int         TURN_BITS    = 2
) (
  input  logic                      iClk,
  input  logic                      iRst,
  nikon_encoder_emu_if.slave        line,
  input  logic [19:0]               iSt_pos,
  input  logic [15:0]               iMt_pos,
  input  logic [3:0]                iAlarm,
  output logic                      oFrame_err,
  output logic                      oBad_cmd,
  output logic                      oResp_done
);
  localparam int            CW      = $clog2((TURN_BITS + 1) * CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] TURN_M1 = CW'(TURN_BITS * CLKS_PER_BIT - 1);

  state_t        state_q, state_d;
  logic          rx_meta_q, rx_sync_q, rx_prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bidx_q, bidx_d;
  logic [10:0]   hdr_q, hdr_d;       // sync, addr, cmd in line order, bit 0 first
  logic          stop_q, stop_d;
  logic [19:0]   st_q, st_d;
  logic [15:0]   mt_q, mt_d;
  logic [3:0]    al_snap_q, al_snap_d, alarm_q, alarm_d;
  logic          cmd0_q, cmd0_d;
  logic          guard_q, guard_d;
  logic [4:0]    fbit_q, fbit_d;
  logic [1:0]    frame_q, frame_d;
  logic          ferr_q, ferr_d, bad_q, bad_d, done_q, done_d;
  logic          rx_fall, crc_ok, tx_bit;
  logic [2:0]    sync_f, addr_f;
  logic [4:0]    cmd_f;
  logic [7:0]    crc8_w;
  logic [15:0]   word;
  logic [3:0]    didx;

  assign rx_fall = rx_prev_q & ~rx_sync_q;
  assign sync_f  = hdr_q[2:0];
  assign addr_f  = hdr_q[5:3];
  assign cmd_f   = hdr_q[10:6];

`ifdef NIKON_EMU_CRC_EN
  logic [2:0]  crcf_q, crcf_d, crc3_w;
  logic [39:0] pl_q, pl_d;           // response payload still to be folded into CRC8
  logic [5:0]  plcnt_q, plcnt_d;
  logic        crc3_clr, crc3_en, crc8_clr, crc8_en;

  nikon_emu_crc #(.W(3), .POLY(CRC3_POLY)) u_crc3 (
    .iClk(iClk), .iRst(iRst), .iClr(crc3_clr), .iEn(crc3_en),
    .iDin(rx_sync_q), .oCrc(crc3_w)
  );
  nikon_emu_crc #(.W(8), .POLY(CRC8_POLY)) u_crc8 (
    .iClk(iClk), .iRst(iRst), .iClr(crc8_clr), .iEn(crc8_en),
    .iDin(pl_q[0]), .oCrc(crc8_w)
  );
  assign crc_ok  = (crc3_w == crcf_q);
  assign crc8_en = (plcnt_q != 6'd0);
`else
  assign crc_ok = 1'b1;
  assign crc8_w = 8'h00;
`endif

  // Line input synchronizer plus one extra stage for falling-edge detection.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= line.iRx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // Next-state, request decode, snapshot and transmit sequencing.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bidx_d    = bidx_q;
    hdr_d     = hdr_q;
    stop_d    = stop_q;
    st_d      = st_q;
    mt_d      = mt_q;
    al_snap_d = al_snap_q;
    cmd0_d    = cmd0_q;
    guard_d   = guard_q;
    fbit_d    = fbit_q;
    frame_d   = frame_q;
    alarm_d   = alarm_q | iAlarm;
    ferr_d    = 1'b0;
    bad_d     = 1'b0;
    done_d    = 1'b0;
`ifdef NIKON_EMU_CRC_EN
    crcf_d   = crcf_q;
    crc3_clr = 1'b0;
    crc3_en  = 1'b0;
    crc8_clr = 1'b0;
    pl_d     = pl_q;
    plcnt_d  = plcnt_q;
    if (crc8_en) begin
      pl_d    = {1'b0, pl_q[39:1]};
      plcnt_d = plcnt_q - 6'd1;
    end
`endif
    case (state_q)
      ST_IDLE: begin
        if (rx_fall) begin
          state_d = ST_RX;
          cnt_d   = '0;
          bidx_d  = 4'd0;
`ifdef NIKON_EMU_CRC_EN
          crc3_clr = 1'b1;
`endif
        end
      end
      ST_RX: begin
        cnt_d = (cnt_q == BIT_M1) ? '0 : cnt_q + 1'b1;
        if (cnt_q == HALF_M1) begin
          bidx_d = bidx_q + 4'd1;
          if (bidx_q >= 4'd1 && bidx_q <= 4'd11) hdr_d = {rx_sync_q, hdr_q[10:1]};
`ifdef NIKON_EMU_CRC_EN
          if (bidx_q >= 4'd12 && bidx_q <= 4'd14) crcf_d = {rx_sync_q, crcf_q[2:1]};
          crc3_en = (bidx_q >= 4'd4 && bidx_q <= 4'd11);
`endif
          if (bidx_q == 4'(REQ_BITS - 1)) begin
            stop_d  = rx_sync_q;
            state_d = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        if (!stop_q || sync_f != SYNC_WORD || !crc_ok) begin
          ferr_d = 1'b1;
        end else if (addr_f == ENC_ADDR) begin
          if (cmd_f == CMD_READ_ALL || cmd_f == CMD_ALARM_CLR) begin
            st_d      = iSt_pos;
            mt_d      = iMt_pos;
            al_snap_d = alarm_q;
            cmd0_d    = (cmd_f == CMD_READ_ALL);
            state_d   = ST_TURN;
            // Clearing keeps any source still asserted this cycle.
            if (cmd_f == CMD_ALARM_CLR) alarm_d = iAlarm;
`ifdef NIKON_EMU_CRC_EN
            crc8_clr = 1'b1;
            if (cmd_f == CMD_READ_ALL) begin
              pl_d    = {iMt_pos[15:12], alarm_q, iMt_pos[11:0], iSt_pos};
              plcnt_d = 6'd40;
            end else begin
              pl_d    = {32'd0, alarm_q, 4'd0};
              plcnt_d = 6'd8;
            end
`endif
          end else begin
            bad_d = 1'b1;
          end
        end
      end
      ST_TURN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == TURN_M1) begin
          state_d = ST_TX;
          cnt_d   = '0;
          guard_d = 1'b1;
          fbit_d  = 5'd0;
          frame_d = 2'd0;
        end
      end
      ST_TX: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == BIT_M1) begin
          cnt_d = '0;
          if (guard_q) begin
            guard_d = 1'b0;
          end else if (fbit_q == 5'(FRAME_BITS - 1)) begin
            fbit_d = 5'd0;
            if (frame_q == (cmd0_q ? 2'd2 : 2'd0)) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              frame_d = frame_q + 2'd1;
            end
          end else begin
            fbit_d = fbit_q + 5'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control state, sticky alarm and status pulses.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bidx_q  <= 4'd0;
      alarm_q <= 4'd0;
      guard_q <= 1'b0;
      fbit_q  <= 5'd0;
      frame_q <= 2'd0;
      ferr_q  <= 1'b0;
      bad_q   <= 1'b0;
      done_q  <= 1'b0;
`ifdef NIKON_EMU_CRC_EN
      plcnt_q <= 6'd0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bidx_q  <= bidx_d;
      alarm_q <= alarm_d;
      guard_q <= guard_d;
      fbit_q  <= fbit_d;
      frame_q <= frame_d;
      ferr_q  <= ferr_d;
      bad_q   <= bad_d;
      done_q  <= done_d;
`ifdef NIKON_EMU_CRC_EN
      plcnt_q <= plcnt_d;
`endif
    end
  end

  // Request fields and response snapshot; always written before being read.
  always_ff @(posedge iClk) begin
    hdr_q     <= hdr_d;
    stop_q    <= stop_d;
    st_q      <= st_d;
    mt_q      <= mt_d;
    al_snap_q <= al_snap_d;
    cmd0_q    <= cmd0_d;
`ifdef NIKON_EMU_CRC_EN
    crcf_q    <= crcf_d;
    pl_q      <= pl_d;
`endif
  end

  // Current response word and the line level for the current bit slot.
  always_comb begin
    case (frame_q)
      2'd0:    word = cmd0_q ? st_q[15:0] : {al_snap_q, 4'd0, crc8_w};
      2'd1:    word = {mt_q[11:0], st_q[19:16]};
      default: word = {mt_q[15:12], al_snap_q, crc8_w};
    endcase
    didx = 4'(fbit_q - 5'd1);
    if (guard_q || fbit_q == 5'(FRAME_BITS - 1)) tx_bit = 1'b1;
    else if (fbit_q == 5'd0)                     tx_bit = 1'b0;
    else                                         tx_bit = word[didx];
  end

  assign line.oTx    = (state_q == ST_TX) ? tx_bit : 1'b1;
  assign line.oDir   = (state_q == ST_TX);
  assign oFrame_err  = ferr_q;
  assign oBad_cmd    = bad_q;
  assign oResp_done  = done_q;
endmodule

// File: tb/tb_nikon_encoder_emu.sv
// tb_nikon_encoder_emu: directed bench for the Nikon encoder emulator.
module tb_nikon_encoder_emu;
  localparam int CPB = 20;

  logic        iClk = 1'b0;
  logic        iRst;
  logic [19:0] st;
  logic [15:0] mt;
  logic [3:0]  al;
  logic        ferr, badc, done;

  int total = 0, bad = 0;
  int n_ferr = 0, n_bad = 0, n_done = 0, n_rise = 0, dir_cur = 0, dir_len = 0;
  int e_ferr = 0, e_bad = 0, e_done = 0, e_rise = 0;
  logic dir_prev = 1'b0;

  logic [15:0] f0, f1, f2;
  bit          ok;
  int          n;

  nikon_encoder_emu_if ifc ();

  nikon_encoder_emu dut (
    .iClk       (iClk),
    .iRst       (iRst),
    .line       (ifc),
    .iSt_pos    (st),
    .iMt_pos    (mt),
    .iAlarm     (al),
    .oFrame_err (ferr),
    .oBad_cmd   (badc),
    .oResp_done (done)
  );

  always #10 iClk = ~iClk;

  // Pulse counters and driver-enable window length.
  always @(negedge iClk) begin
    if (ferr) n_ferr++;
    if (badc) n_bad++;
    if (done) n_done++;
    if (ifc.oDir) dir_cur++;
    if (ifc.oDir && !dir_prev) n_rise++;
    if (!ifc.oDir && dir_prev) begin
      dir_len = dir_cur;
      dir_cur = 0;
    end
    dir_prev = ifc.oDir;
  end

  function automatic logic [2:0] m_crc3(input logic [2:0] a, input logic [4:0] c);
    logic [7:0] v;
    logic [2:0] r;
    logic       fb;
    v = {c, a};
    r = 3'd0;
    for (int i = 0; i < 8; i++) begin
      fb = r[2] ^ v[i];
      r  = {r[1:0], 1'b0} ^ (fb ? 3'b011 : 3'b000);
    end
    return r;
  endfunction

  function automatic logic [7:0] m_crc8(input logic [39:0] v, input int nb);
    logic [7:0] r;
    logic       fb;
    r = 8'd0;
    for (int i = 0; i < nb; i++) begin
      fb = r[7] ^ v[i];
      r  = {r[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return r;
  endfunction

  function automatic logic [7:0] exp_crc_all(input logic [19:0] s, input logic [15:0] m,
                                             input logic [3:0] a);
`ifdef NIKON_EMU_CRC_EN
    return m_crc8({m[15:12], a, m[11:0], s}, 40);
`else
    return 8'h00;
`endif
  endfunction

  function automatic logic [7:0] exp_crc_clr(input logic [3:0] a);
`ifdef NIKON_EMU_CRC_EN
    return m_crc8({32'd0, a, 4'd0}, 8);
`else
    return 8'h00;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one request frame, one bit per CPB clocks, starting on a falling edge.
  task automatic send_req(input logic [2:0] a, input logic [4:0] c,
                          input logic [2:0] crcx, input logic [2:0] syncv);
    logic [15:0] fr;
    fr = {1'b1, m_crc3(a, c) ^ crcx, c, a, syncv, 1'b0};
    for (int i = 0; i < 16; i++) begin
      ifc.iRx = fr[i];
      repeat (CPB) @(negedge iClk);
    end
  endtask

  // Receive one response frame, sampling each bit in its middle.
  task automatic recv_frame(output logic [15:0] d, output bit fok);
    int k;
    k   = 0;
    fok = 1'b1;
    d   = '0;
    while (ifc.oTx !== 1'b0 && k < 3000) begin
      @(negedge iClk);
      k++;
    end
    if (k >= 3000) begin
      fok = 1'b0;
      return;
    end
    repeat (CPB / 2) @(negedge iClk);
    if (ifc.oTx !== 1'b0) fok = 1'b0;
    for (int i = 0; i < 16; i++) begin
      repeat (CPB) @(negedge iClk);
      d[i] = ifc.oTx;
    end
    repeat (CPB) @(negedge iClk);
    if (ifc.oTx !== 1'b1) fok = 1'b0;
  endtask

  task automatic wait_dir_low(input string tag);
    int k;
    k = 0;
    while (ifc.oDir !== 1'b0 && k < 5000) begin
      @(negedge iClk);
      k++;
    end
    chk({tag, "_dir_low"}, 32'(k < 5000), 32'd1);
    repeat (5) @(negedge iClk);
  endtask

  task automatic recv_all(input string tag, input logic [19:0] s, input logic [15:0] m,
                          input logic [3:0] a);
    recv_frame(f0, ok); chk({tag, "_f0_ok"}, 32'(ok), 32'd1);
    recv_frame(f1, ok); chk({tag, "_f1_ok"}, 32'(ok), 32'd1);
    recv_frame(f2, ok); chk({tag, "_f2_ok"}, 32'(ok), 32'd1);
    chk({tag, "_f0"}, 32'(f0), 32'(s[15:0]));
    chk({tag, "_f1"}, 32'(f1), 32'({m[11:0], s[19:16]}));
    chk({tag, "_f2_hi"}, 32'(f2[15:8]), 32'({m[15:12], a}));
    chk({tag, "_crc8"}, 32'(f2[7:0]), 32'(exp_crc_all(s, m, a)));
  endtask

  initial begin
    iRst    = 1'b1;
    ifc.iRx = 1'b1;
    st = '0; mt = '0; al = '0;
    repeat (3) @(negedge iClk);
    chk("rst_tx", 32'(ifc.oTx), 32'd1);
    chk("rst_dir", 32'(ifc.oDir), 32'd0);
    chk("rst_ferr", 32'(ferr), 32'd0);
    chk("rst_bad", 32'(badc), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    iRst = 1'b0;
    repeat (5) @(negedge iClk);

    // Read-all, hand-computed response words; inputs change after the snapshot.
    st = 20'hABCDE; mt = 16'h1234;
    send_req(3'd0, 5'd0, 3'd0, 3'b010);
    st = 20'h55555; mt = 16'hAAAA;
    n = 0;
    while (ifc.oDir !== 1'b1 && n < 500) begin @(negedge iClk); n++; end
    chk("t1_dir_rise", 32'(n < 500), 32'd1);
    n = 0;
    while (ifc.oTx !== 1'b0 && n < 500) begin @(negedge iClk); n++; end
    chk("t1_guard", 32'(n), 32'(CPB));
    recv_frame(f0, ok); chk("t1_f0_ok", 32'(ok), 32'd1);
    recv_frame(f1, ok); chk("t1_f1_ok", 32'(ok), 32'd1);
    recv_frame(f2, ok); chk("t1_f2_ok", 32'(ok), 32'd1);
    chk("t1_f0", 32'(f0), 32'h0000BCDE);
    chk("t1_f1", 32'(f1), 32'h0000234A);
    chk("t1_f2_hi", 32'(f2[15:8]), 32'h10);
    chk("t1_crc8", 32'(f2[7:0]), 32'(exp_crc_all(20'hABCDE, 16'h1234, 4'h0)));
    wait_dir_low("t1");
    e_rise++; e_done++;
    chk("t1_dir_len", 32'(dir_len), 32'(55 * CPB));
    chk("t1_done", 32'(n_done), 32'(e_done));
    chk("t1_ferr", 32'(n_ferr), 32'(e_ferr));

    // Foreign address: silent.
    send_req(3'd5, 5'd0, 3'd0, 3'b010);
    repeat (300) @(negedge iClk);
    chk("t2_rise", 32'(n_rise), 32'(e_rise));
    chk("t2_ferr", 32'(n_ferr), 32'(e_ferr));
    chk("t2_bad", 32'(n_bad), 32'(e_bad));
    chk("t2_done", 32'(n_done), 32'(e_done));

    // Corrupted crc3 field.
    st = 20'h13579; mt = 16'h2468;
    send_req(3'd0, 5'd0, 3'b001, 3'b010);
`ifdef NIKON_EMU_CRC_EN
    repeat (300) @(negedge iClk);
    e_ferr++;
`else
    recv_all("t3", 20'h13579, 16'h2468, 4'h0);
    wait_dir_low("t3");
    e_rise++; e_done++;
`endif
    chk("t3_ferr", 32'(n_ferr), 32'(e_ferr));
    chk("t3_rise", 32'(n_rise), 32'(e_rise));
    chk("t3_done", 32'(n_done), 32'(e_done));

    // Wrong sync word is a framing error in every build.
    send_req(3'd0, 5'd0, 3'd0, 3'b011);
    repeat (300) @(negedge iClk);
    e_ferr++;
    chk("t4_ferr", 32'(n_ferr), 32'(e_ferr));
    chk("t4_rise", 32'(n_rise), 32'(e_rise));

    // Sticky alarm, then alarm clear.
    al = 4'b0100;
    @(negedge iClk);
    al = 4'b0000;
    repeat (5) @(negedge iClk);
    send_req(3'd0, 5'd1, 3'd0, 3'b010);
    recv_frame(f0, ok); chk("t5_ok", 32'(ok), 32'd1);
    chk("t5_alarm", 32'(f0[15:12]), 32'h4);
    chk("t5_zero", 32'(f0[11:8]), 32'h0);
    chk("t5_crc8", 32'(f0[7:0]), 32'(exp_crc_clr(4'b0100)));
    wait_dir_low("t5");
    e_rise++; e_done++;
    chk("t5_dir_len", 32'(dir_len), 32'(19 * CPB));
    chk("t5_done", 32'(n_done), 32'(e_done));
    st = 20'h0F00F; mt = 16'h8001;
    send_req(3'd0, 5'd0, 3'd0, 3'b010);
    recv_all("t5b", 20'h0F00F, 16'h8001, 4'h0);
    wait_dir_low("t5b");
    e_rise++; e_done++;
    chk("t5b_alarm", 32'(f2[11:8]), 32'h0);

    // Unsupported command.
    send_req(3'd0, 5'd7, 3'd0, 3'b010);
    repeat (300) @(negedge iClk);
    e_bad++;
    chk("t6_bad", 32'(n_bad), 32'(e_bad));
    chk("t6_rise", 32'(n_rise), 32'(e_rise));

    // Reset in the middle of F1, then a normal transaction.
    st = 20'hABCDE; mt = 16'h1234;
    send_req(3'd0, 5'd0, 3'd0, 3'b010);
    recv_frame(f0, ok);
    e_rise++;
    chk("t7_f0", 32'(f0), 32'h0000BCDE);
    repeat (150) @(negedge iClk);
    chk("t7_mid_dir", 32'(ifc.oDir), 32'd1);
    iRst = 1'b1;
    #1;
    chk("t7_rst_tx", 32'(ifc.oTx), 32'd1);
    chk("t7_rst_dir", 32'(ifc.oDir), 32'd0);
    repeat (3) @(negedge iClk);
    iRst = 1'b0;
    repeat (5) @(negedge iClk);
    chk("t7_no_done", 32'(n_done), 32'(e_done));
    st = 20'h12345; mt = 16'hFEDC;
    send_req(3'd0, 5'd0, 3'd0, 3'b010);
    recv_frame(f0, ok); chk("t8_f0_ok", 32'(ok), 32'd1);
    recv_frame(f1, ok); chk("t8_f1_ok", 32'(ok), 32'd1);
    recv_frame(f2, ok); chk("t8_f2_ok", 32'(ok), 32'd1);
    chk("t8_f0", 32'(f0), 32'h00002345);
    chk("t8_f1", 32'(f1), 32'h0000EDC1);
    chk("t8_f2_hi", 32'(f2[15:8]), 32'hF0);
    chk("t8_crc8", 32'(f2[7:0]), 32'(exp_crc_all(20'h12345, 16'hFEDC, 4'h0)));
    wait_dir_low("t8");
    e_rise++; e_done++;
    chk("t8_done", 32'(n_done), 32'(e_done));
    chk("t8_rise", 32'(n_rise), 32'(e_rise));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
